map_port_arbiter: RTL and testbench

- Sits between the on-chip map tile RAM (128x96 tiles, 24-bit colour per tile) and the game logic.
- Shares the single write port between two tile-write requesters and a built-in rectangular fill engine.
- Gives game-logic tile reads the RAM read port only while the display is not in active video. The VGA pixel path owns the read port at all other times.

---
 rtl/map_pkg.sv | 15 +
 rtl/map_fill_engine.sv | 84 ++++++++
 rtl/map_port_arbiter.sv | 119 +++++++++++
 tb/tb_map_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// map_pkg: shared map geometry, tile/pixel types, fill FSM states and tile address helper.
package map_pkg;
    localparam int MAP_W  = 128;
    localparam int MAP_H  = 96;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 14;

    typedef logic [ADDR_W-1:0] tile_addr_t;
    typedef logic [DATA_W-1:0] pixel_t;
    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    function automatic tile_addr_t tile_addr(input logic [7:0] x, input logic [6:0] y);
        return tile_addr_t'(y) * tile_addr_t'(MAP_W) + tile_addr_t'(x);
    endfunction
endpackage

// File: rtl/map_fill_engine.sv
// map_fill_engine: clipped rectangular fill FSM issuing one raster-order tile write per cycle.
module map_fill_engine
    import map_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_x0,
    input  logic [7:0]        i_w,
    input  logic [6:0]        i_y0,
    input  logic [6:0]        i_h,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done
);
    fill_state_t r_state;
    logic [7:0]  r_x, r_x0, r_xl;
    logic [6:0]  r_y, r_yl;
    pixel_t      r_data;
    logic        r_busy, r_done;
    logic [8:0]  w_xe;
    logic [7:0]  w_ye;
    logic [7:0]  w_xl;
    logic [6:0]  w_yl;
    logic        w_empty;

    // Exclusive end coordinates are clamped to the map edge so rows never wrap.
    assign w_xe    = 9'(i_x0) + 9'(i_w);
    assign w_ye    = 8'(i_y0) + 8'(i_h);
    assign w_xl    = (w_xe > 9'(MAP_W)) ? 8'(MAP_W - 1) : 8'(w_xe - 9'd1);
    assign w_yl    = (w_ye > 8'(MAP_H)) ? 7'(MAP_H - 1) : 7'(w_ye - 8'd1);
    assign w_empty = (i_w == '0) || (i_h == '0) || (9'(i_x0) >= 9'(MAP_W)) || (8'(i_y0) >= 8'(MAP_H));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= '0;
            r_x0    <= '0;
            r_xl    <= '0;
            r_y     <= '0;
            r_yl    <= '0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_x     <= i_x0;
                    r_x0    <= i_x0;
                    r_xl    <= w_xl;
                    r_y     <= i_y0;
                    r_yl    <= w_yl;
                    r_data  <= i_data;
                    r_state <= w_empty ? DONE : FILL;
                    r_busy  <= ~w_empty;
                    r_done  <= w_empty;
                end
                FILL: if (r_x == r_xl) begin
                    r_x <= r_x0;
                    if (r_y == r_yl) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_y <= r_y + 7'd1;
                    end
                end else begin
                    r_x <= r_x + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_we   = (r_state == FILL);
    assign o_addr = tile_addr(r_x, r_y);
    assign o_data = r_data;
    assign o_busy = r_busy;
    assign o_done = r_done;
endmodule

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: map tile RAM port arbiter for two writers, a fill engine and a blanking-only reader.
// Build option MAP_FWD_EN: a read colliding with a same-cycle write returns the new write data.
module map_port_arbiter
    import map_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_disp_active,
    input  logic [1:0]        i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr0,
    input  logic [ADDR_W-1:0] i_wr_addr1,
    input  logic [DATA_W-1:0] i_wr_data0,
    input  logic [DATA_W-1:0] i_wr_data1,
    output logic [1:0]        o_wr_gnt,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_gnt,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_fill_start,
    input  logic [7:0]        i_fill_x0,
    input  logic [7:0]        i_fill_w,
    input  logic [6:0]        i_fill_y0,
    input  logic [6:0]        i_fill_h,
    input  logic [DATA_W-1:0] i_fill_data,
    output logic              o_fill_busy,
    output logic              o_fill_done,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_rsel,
    output logic [ADDR_W-1:0] o_ram_raddr,
    input  logic [DATA_W-1:0] i_ram_rdata
);
    logic       w_fill_we, w_fill_busy, w_fill_done, w_rd_gnt;
    tile_addr_t w_fill_addr;
    pixel_t     w_fill_data, w_rd_word;
    logic [1:0] w_gnt;
    logic       r_ptr, r_ram_we, r_rsel, r_valid;
    tile_addr_t r_waddr, r_raddr;
    pixel_t     r_wdata;

    map_fill_engine u_fill (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_fill_start),
        .i_x0    (i_fill_x0),
        .i_w     (i_fill_w),
        .i_y0    (i_fill_y0),
        .i_h     (i_fill_h),
        .i_data  (i_fill_data),
        .o_we    (w_fill_we),
        .o_addr  (w_fill_addr),
        .o_data  (w_fill_data),
        .o_busy  (w_fill_busy),
        .o_done  (w_fill_done)
    );

    // r_ptr remembers the last tie winner; a tie goes to the other requester.
    assign w_gnt    = (i_reset || w_fill_busy) ? 2'b00 : (&i_wr_req) ? (r_ptr ? 2'b01 : 2'b10) : i_wr_req;
    assign w_rd_gnt = i_rd_req & ~i_disp_active & ~r_rsel & ~i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr    <= 1'b1;
            r_ram_we <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_rsel   <= 1'b0;
            r_raddr  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_ram_we <= w_fill_we | (|w_gnt);
            if (w_fill_we) begin
                r_waddr <= w_fill_addr;
                r_wdata <= w_fill_data;
            end else if (|w_gnt) begin
                r_waddr <= w_gnt[1] ? i_wr_addr1 : i_wr_addr0;
                r_wdata <= w_gnt[1] ? i_wr_data1 : i_wr_data0;
            end
            if (&i_wr_req && |w_gnt) r_ptr <= w_gnt[1];
            r_rsel  <= w_rd_gnt;
            if (w_rd_gnt) r_raddr <= i_rd_addr;
            r_valid <= r_rsel;
        end
    end

`ifdef MAP_FWD_EN
    logic   r_fwd;
    pixel_t r_fwd_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd      <= r_rsel & r_ram_we & (r_waddr == r_raddr);
            r_fwd_data <= r_wdata;
        end
    end

    assign w_rd_word = r_fwd ? r_fwd_data : i_ram_rdata;
`else
    assign w_rd_word = i_ram_rdata;
`endif

    // The RAM returns data in the valid cycle, so it is gated rather than re-registered.
    assign o_rd_data   = r_valid ? w_rd_word : '0;
    assign o_rd_valid  = r_valid;
    assign o_wr_gnt    = w_gnt;
    assign o_rd_gnt    = w_rd_gnt;
    assign o_fill_busy = w_fill_busy;
    assign o_fill_done = w_fill_done;
    assign o_ram_we    = r_ram_we;
    assign o_ram_waddr = r_waddr;
    assign o_ram_wdata = r_wdata;
    assign o_ram_rsel  = r_rsel;
    assign o_ram_raddr = r_raddr;
endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: directed bench with write/read scoreboards against a behavioural tile RAM.
module tb_map_port_arbiter;
    logic        clk = 1'b0, rst, disp_active, rd_req, rd_gnt, rd_valid, fill_start, fill_busy, fill_done;
    logic        ram_we, ram_rsel;
    logic [1:0]  wr_req, wr_gnt;
    logic [13:0] wr_addr0, wr_addr1, rd_addr, ram_waddr, ram_raddr;
    logic [23:0] wr_data0, wr_data1, rd_data, fill_data, ram_wdata, ram_rdata;
    logic [7:0]  fill_x0, fill_w;
    logic [6:0]  fill_y0, fill_h;
    logic [23:0] mem [0:16383];
    logic [37:0] wq[$];
    logic [23:0] rq[$];
    int          checks = 0, errors = 0;

`ifdef MAP_FWD_EN
    localparam logic [23:0] FWD_EXP = 24'h00ABCD;
`else
    localparam logic [23:0] FWD_EXP = 24'h000111;
`endif

    map_port_arbiter dut (
        .i_clk(clk), .i_reset(rst), .i_disp_active(disp_active),
        .i_wr_req(wr_req), .i_wr_addr0(wr_addr0), .i_wr_addr1(wr_addr1),
        .i_wr_data0(wr_data0), .i_wr_data1(wr_data1), .o_wr_gnt(wr_gnt),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .i_fill_start(fill_start), .i_fill_x0(fill_x0), .i_fill_w(fill_w),
        .i_fill_y0(fill_y0), .i_fill_h(fill_h), .i_fill_data(fill_data),
        .o_fill_busy(fill_busy), .o_fill_done(fill_done),
        .o_ram_we(ram_we), .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata),
        .o_ram_rsel(ram_rsel), .o_ram_raddr(ram_raddr), .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM; reset preloads the two locations the reads expect.
    always @(posedge clk) begin
        if (rst) begin
            mem[14'h0105] <= 24'h123456;
            mem[14'h0042] <= 24'h000111;
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            checks++;
            assert (wq.size() > 0) else begin
                errors++;
                $error("FAIL wr_unexpected: observed write %h:%h expected none", ram_waddr, ram_wdata);
            end
            if (wq.size() > 0) chk("wr_commit", 64'({ram_waddr, ram_wdata}), 64'(wq.pop_front()));
        end
        if (rd_valid === 1'b1) begin
            checks++;
            assert (rq.size() > 0) else begin
                errors++;
                $error("FAIL rd_unexpected: observed read %h expected none", rd_data);
            end
            if (rq.size() > 0) chk("rd_data", 64'(rd_data), 64'(rq.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; disp_active = 1'b0; rd_req = 1'b0; rd_addr = '0; fill_start = 1'b0;
        wr_req = 2'b00; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        fill_x0 = '0; fill_w = '0; fill_y0 = '0; fill_h = '0; fill_data = '0;
        cyc(); cyc();
        mid();
        chk("rst_ram_we", 64'(ram_we), 64'(0));
        chk("rst_ram_waddr", 64'(ram_waddr), 64'(0));
        chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
        chk("rst_ram_rsel", 64'(ram_rsel), 64'(0));
        chk("rst_ram_raddr", 64'(ram_raddr), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_fill_busy", 64'(fill_busy), 64'(0));
        chk("rst_fill_done", 64'(fill_done), 64'(0));
        cyc();
        // Round-robin tie between both requesters.
        rst = 1'b0; wr_req = 2'b11;
        wr_addr0 = 14'h0010; wr_data0 = 24'hA00001; wr_addr1 = 14'h0020; wr_data1 = 24'hB00002;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("tie_gnt", 64'(wr_gnt), 64'(i[0] ? 2'b10 : 2'b01));
            wq.push_back(i[0] ? {14'h0020, 24'hB00002} : {14'h0010, 24'hA00001});
            cyc();
        end
        wr_req = 2'b00;
        mid(); cyc();
        mid(); chk("idle_ram_we", 64'(ram_we), 64'(0)); cyc();
        // Edge-clipped fill with a requester held off; repeated start while busy is ignored.
        fill_x0 = 8'd126; fill_y0 = 7'd95; fill_w = 8'd4; fill_h = 7'd3; fill_data = 24'hFF0000; fill_start = 1'b1;
        wq.push_back({14'h2FFE, 24'hFF0000});
        wq.push_back({14'h2FFF, 24'hFF0000});
        mid(); chk("fill_busy_start", 64'(fill_busy), 64'(0)); cyc();
        wr_req = 2'b01; wr_addr0 = 14'h0300; wr_data0 = 24'h111111;
        mid();
        chk("fill_busy_1", 64'(fill_busy), 64'(1));
        chk("fill_gnt_1", 64'(wr_gnt), 64'(0));
        chk("fill_done_1", 64'(fill_done), 64'(0));
        cyc();
        mid();
        chk("fill_busy_2", 64'(fill_busy), 64'(1));
        chk("fill_gnt_2", 64'(wr_gnt), 64'(0));
        cyc();
        fill_start = 1'b0;
        mid();
        chk("fill_busy_done", 64'(fill_busy), 64'(0));
        chk("fill_done_pulse", 64'(fill_done), 64'(1));
        chk("fill_gnt_after", 64'(wr_gnt), 64'(2'b01));
        wq.push_back({14'h0300, 24'h111111});
        cyc();
        wr_req = 2'b00;
        mid();
        chk("fill_done_end", 64'(fill_done), 64'(0));
        chk("fill_busy_end", 64'(fill_busy), 64'(0));
        cyc();
        // Empty fill: completes without writes.
        fill_x0 = 8'd10; fill_y0 = 7'd10; fill_w = 8'd0; fill_h = 7'd3; fill_start = 1'b1;
        mid(); chk("empty_done_0", 64'(fill_done), 64'(0)); cyc();
        fill_start = 1'b0;
        mid();
        chk("empty_done_1", 64'(fill_done), 64'(1));
        chk("empty_busy_1", 64'(fill_busy), 64'(0));
        chk("empty_we_1", 64'(ram_we), 64'(0));
        cyc();
        mid();
        chk("empty_done_2", 64'(fill_done), 64'(0));
        chk("empty_we_2", 64'(ram_we), 64'(0));
        cyc();
        // Read blocked during active video, granted once it drops.
        rd_addr = 14'h0105; rd_req = 1'b1; disp_active = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mid(); chk("rd_blocked", 64'(rd_gnt), 64'(0)); cyc();
        end
        disp_active = 1'b0;
        mid(); chk("rd_gnt", 64'(rd_gnt), 64'(1)); rq.push_back(24'h123456); cyc();
        rd_req = 1'b0; disp_active = 1'b1;
        mid();
        chk("rd_rsel", 64'(ram_rsel), 64'(1));
        chk("rd_raddr", 64'(ram_raddr), 64'(14'h0105));
        chk("rd_valid_early", 64'(rd_valid), 64'(0));
        cyc();
        mid();
        chk("rd_rsel_pulse", 64'(ram_rsel), 64'(0));
        chk("rd_valid", 64'(rd_valid), 64'(1));
        cyc();
        mid(); chk("rd_valid_pulse", 64'(rd_valid), 64'(0)); cyc();
        // Read and write of 0x0042 in the same RAM cycle.
        disp_active = 1'b0; wr_req = 2'b11;
        wr_addr0 = 14'h0042; wr_data0 = 24'h00ABCD; wr_addr1 = 14'h0050; wr_data1 = 24'h555555;
        rd_req = 1'b1; rd_addr = 14'h0042;
        mid();
        chk("col_wr_gnt", 64'(wr_gnt), 64'(2'b01));
        chk("col_rd_gnt", 64'(rd_gnt), 64'(1));
        wq.push_back({14'h0042, 24'h00ABCD});
        rq.push_back(FWD_EXP);
        cyc();
        wr_req = 2'b10;
        mid();
        chk("col_wr_gnt1", 64'(wr_gnt), 64'(2'b10));
        chk("col_rd_inflight", 64'(rd_gnt), 64'(0));
        wq.push_back({14'h0050, 24'h555555});
        cyc();
        wr_req = 2'b00;
        mid(); chk("reread_gnt", 64'(rd_gnt), 64'(1)); rq.push_back(24'h00ABCD); cyc();
        rd_req = 1'b0;
        mid(); cyc();
        mid(); cyc();
        // 5x5 fill aborted by reset while its 10th write is issued.
        fill_x0 = 8'd10; fill_y0 = 7'd20; fill_w = 8'd5; fill_h = 7'd5; fill_data = 24'h0000FF; fill_start = 1'b1;
        for (int i = 0; i < 9; i++) wq.push_back({14'((20 + i / 5) * 128 + 10 + i % 5), 24'h0000FF});
        mid(); cyc();
        fill_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mid(); cyc();
        end
        rst = 1'b1;
        mid(); chk("abort_busy_before", 64'(fill_busy), 64'(1)); cyc();
        rst = 1'b0; wr_req = 2'b11;
        wr_addr0 = 14'h00A0; wr_data0 = 24'hCCCC01; wr_addr1 = 14'h00B0; wr_data1 = 24'hDDDD02;
        mid();
        chk("abort_we", 64'(ram_we), 64'(0));
        chk("abort_busy", 64'(fill_busy), 64'(0));
        chk("abort_done", 64'(fill_done), 64'(0));
        chk("post_rst_gnt0", 64'(wr_gnt), 64'(2'b01));
        wq.push_back({14'h00A0, 24'hCCCC01});
        cyc();
        mid();
        chk("post_rst_gnt1", 64'(wr_gnt), 64'(2'b10));
        chk("abort_done_2", 64'(fill_done), 64'(0));
        wq.push_back({14'h00B0, 24'hDDDD02});
        cyc();
        wr_req = 2'b00;
        mid(); chk("abort_done_3", 64'(fill_done), 64'(0)); cyc();
        mid(); cyc();
        mid();
        chk("wq_drained", 64'(wq.size()), 64'(0));
        chk("rq_drained", 64'(rq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
